// File: rtl/syscall_pkg.sv
//------------------------------------------------------------------------------
// Module   : syscall_pkg
// Purpose  : Shared syscall codes and FSM state encoding for the syscall unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package syscall_pkg;

    localparam int SYS_PRINT_INT  = 1;
    localparam int SYS_EXIT       = 10;
    localparam int SYS_PRINT_CHAR = 11;
    localparam int SYS_EXIT2      = 17;
    localparam int SYS_TIME       = 30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage : syscall_pkg

`default_nettype wire

// File: rtl/syscall_char_fifo.sv
//------------------------------------------------------------------------------
// Module   : syscall_char_fifo
// Purpose  : Power-of-two circular character FIFO with occupancy counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module syscall_char_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd_ptr];

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule : syscall_char_fifo

`default_nettype wire

// File: rtl/syscall_unit.sv
//------------------------------------------------------------------------------
// Module   : syscall_unit
// Purpose  : Syscall decode/service: print-int, buffered print-char, exit, time.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module syscall_unit
    import syscall_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CODE_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [CODE_W-1:0] v0,
    input  logic [DATA_W-1:0] a0,
    output logic              stall,
    output logic              halt,
    output logic [DATA_W-1:0] exit_code,
    output logic [DATA_W-1:0] hex_out,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_we,
    output logic              char_valid,
    output logic [7:0]        char_data,
    input  logic              char_ready,
    output logic              bad_code
);

    localparam logic [CODE_W-1:0] c_print_int  = CODE_W'(SYS_PRINT_INT);
    localparam logic [CODE_W-1:0] c_exit       = CODE_W'(SYS_EXIT);
    localparam logic [CODE_W-1:0] c_print_char = CODE_W'(SYS_PRINT_CHAR);
    localparam logic [CODE_W-1:0] c_exit2      = CODE_W'(SYS_EXIT2);
    localparam logic [CODE_W-1:0] c_time       = CODE_W'(SYS_TIME);

    state_t            r_state;
    logic [DATA_W-1:0] r_cycle_cnt;
    logic [DATA_W-1:0] r_hex;
    logic [DATA_W-1:0] r_exit_code;
    logic              r_halt;
    logic              r_bad_code;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_commit;
    logic              w_push;
    logic              w_pop;

    // A full FIFO stalls print-char even if the head pops this cycle.
    always_comb begin
        stall = 1'b1;
        if (r_state == IDLE)
            stall = enable && (v0 == c_print_char) && w_fifo_full;
    end

    assign w_commit   = enable && !stall && (r_state == IDLE);
    assign w_push     = w_commit && (v0 == c_print_char);
    assign w_pop      = char_valid && char_ready;
    assign char_valid = !w_fifo_empty;
    assign rd_we      = w_commit && (v0 == c_time);
    assign rd_data    = rd_we ? r_cycle_cnt : '0;
    assign halt       = r_halt;
    assign hex_out    = r_hex;
    assign exit_code  = r_exit_code;
    assign bad_code   = r_bad_code;

    syscall_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_char_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (a0[7:0]),
        .pop   (w_pop),
        .dout  (char_data),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cycle_cnt <= '0;
            r_hex       <= '0;
            r_exit_code <= '0;
            r_halt      <= 1'b0;
            r_bad_code  <= 1'b0;
        end else begin
            if (!r_halt) r_cycle_cnt <= r_cycle_cnt + 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_commit) begin
                        case (v0)
                            c_print_int:  r_hex <= a0;
                            c_exit: begin
                                r_exit_code <= '0;
                                r_state     <= DRAIN;
                            end
                            c_exit2: begin
                                r_exit_code <= a0;
                                r_state     <= DRAIN;
                            end
                            c_print_char, c_time: ;
                            default:      r_bad_code <= 1'b1;
                        endcase
                    end
                end
                DRAIN: begin
                    if (w_fifo_empty) begin
                        r_state <= HALTED;
                        r_halt  <= 1'b1;
                    end
                end
                HALTED:  r_state <= HALTED;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : syscall_unit

`default_nettype wire

// File: tb/tb_syscall_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_syscall_unit
// Purpose  : Self-checking bench for syscall_unit against a queue-based model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_syscall_unit;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [7:0]  v0;
    logic [31:0] a0;
    logic        char_ready;
    logic        stall, halt, rd_we, char_valid, bad_code;
    logic [31:0] exit_code, hex_out, rd_data;
    logic [7:0]  char_data;

    // Narrow second instance so counter wrap is reachable in a few hundred cycles.
    logic        enable_b;
    logic [7:0]  v0_b;
    logic [7:0]  a0_b;
    logic        stall_b, halt_b, rd_we_b, char_valid_b, bad_code_b;
    logic [7:0]  exit_code_b, hex_out_b, rd_data_b, char_data_b;

    always #5 clk = ~clk;

    syscall_unit #(.DATA_W(32), .CODE_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .v0(v0), .a0(a0),
        .stall(stall), .halt(halt), .exit_code(exit_code), .hex_out(hex_out),
        .rd_data(rd_data), .rd_we(rd_we), .char_valid(char_valid),
        .char_data(char_data), .char_ready(char_ready), .bad_code(bad_code)
    );

    syscall_unit #(.DATA_W(8), .CODE_W(8), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable_b), .v0(v0_b), .a0(a0_b),
        .stall(stall_b), .halt(halt_b), .exit_code(exit_code_b), .hex_out(hex_out_b),
        .rd_data(rd_data_b), .rd_we(rd_we_b), .char_valid(char_valid_b),
        .char_data(char_data_b), .char_ready(1'b1), .bad_code(bad_code_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: queue of pending chars plus a few status flags.
    logic [7:0]  q[$];
    bit          m_exiting, m_halted, m_bad;
    logic [31:0] m_cnt, m_hex, m_exit;
    logic [7:0]  m_cnt_b;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        enable_b = 1'b0;
        v0       = '0;
        a0       = '0;
        char_ready = 1'b0;
        #1;
        chk("rst_halt", halt, 0);
        chk("rst_hex", hex_out, 0);
        chk("rst_exit", exit_code, 0);
        chk("rst_bad", bad_code, 0);
        chk("rst_cvalid", char_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rdwe", rd_we, 0);
        q.delete();
        m_exiting = 0; m_halted = 0; m_bad = 0;
        m_cnt = 0; m_hex = 0; m_exit = 0; m_cnt_b = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs before the edge, advance model.
    task automatic step(input bit en, input logic [7:0] code, input logic [31:0] arg,
                        input bit rdy, input bit time_b);
        bit e_stall, commit, pop, e_rdwe;
        enable = en; v0 = code; a0 = arg; char_ready = rdy;
        enable_b = time_b; v0_b = 8'd30; a0_b = '0;
        #1;
        e_stall = m_exiting || m_halted || (en && code == 8'd11 && q.size() == DEPTH);
        commit  = en && !e_stall;
        pop     = (q.size() != 0) && rdy;
        e_rdwe  = commit && code == 8'd30;
        chk("stall", stall, e_stall);
        chk("rd_we", rd_we, e_rdwe);
        chk("rd_data", rd_data, e_rdwe ? m_cnt : 32'd0);
        chk("halt", halt, m_halted);
        chk("hex_out", hex_out, m_hex);
        chk("exit_code", exit_code, m_exit);
        chk("bad_code", bad_code, m_bad);
        chk("char_valid", char_valid, q.size() != 0);
        if (q.size() != 0) chk("char_data", char_data, q[0]);
        chk("rd_we_b", rd_we_b, time_b);
        chk("rd_data_b", rd_data_b, time_b ? m_cnt_b : 8'd0);
        @(posedge clk);
        if (!m_halted) m_cnt = m_cnt + 1;
        m_cnt_b = m_cnt_b + 1;
        if (m_exiting && q.size() == 0) begin
            m_exiting = 0;
            m_halted  = 1;
        end
        if (pop) void'(q.pop_front());
        if (commit) begin
            case (code)
                8'd1:  m_hex = arg;
                8'd10: begin m_exit = 0;   m_exiting = 1; end
                8'd11: q.push_back(arg[7:0]);
                8'd17: begin m_exit = arg; m_exiting = 1; end
                8'd30: ;
                default: m_bad = 1;
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] codes [9];
        int         guard;
        codes = '{8'd1, 8'd11, 8'd11, 8'd11, 8'd30, 8'd30, 8'd99, 8'd1, 8'd11};

        @(negedge clk);
        do_reset();

        // print-int
        step(1, 8'd1, 32'hDEADBEEF, 0, 0);
        chk("t1_hex", hex_out, 32'hDEADBEEF);

        // fill FIFO, ninth char stalls, pop while full still stalls
        for (int i = 0; i < 9; i++) step(1, 8'd11, 32'h41 + i, 0, 0);
        chk("t2_full_stall", stall, 1);
        step(1, 8'd11, 32'h49, 1, 0);
        step(1, 8'd11, 32'h49, 0, 0);
        for (int k = 1; k < 9; k++) begin
            chk("t2_order", char_data, 8'h41 + k);
            step(0, 8'd0, 32'd0, 1, 0);
        end
        chk("t2_empty", char_valid, 0);

        // exit2 with three queued chars
        for (int i = 0; i < 3; i++) step(1, 8'd11, 32'h61 + i, 0, 0);
        step(1, 8'd17, 32'd5, 0, 0);
        guard = 0;
        while (!m_halted && guard < 10) begin
            step(1, 8'd1, 32'h1234, 1, 0);
            guard++;
        end
        chk("t3_halt", halt, 1);
        chk("t3_exit", exit_code, 32'd5);
        do_reset();

        // exit with empty FIFO, then ignored enable
        step(1, 8'd10, 32'd77, 0, 0);
        step(0, 8'd0, 32'd0, 0, 0);
        step(1, 8'd1, 32'h55, 0, 0);
        chk("t4_halt", halt, 1);
        for (int i = 0; i < 3; i++) step(1, 8'd1, 32'h99, 1, 0);
        chk("t4_hex_kept", hex_out, 32'h0);
        do_reset();

        // time read at counter 7
        for (int i = 0; i < 7; i++) step(0, 8'd0, 32'd0, 0, 0);
        enable = 1; v0 = 8'd30; #1;
        chk("t5_time7", rd_data, 32'd7);
        step(1, 8'd30, 32'd0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] c;
            if (m_halted) do_reset();
            c = codes[$urandom_range(0, 8)];
            if ($urandom_range(0, 39) == 0) c = ($urandom_range(0, 1) != 0) ? 8'd10 : 8'd17;
            step($urandom_range(0, 1) != 0, c, $urandom, $urandom_range(0, 2) != 0, 0);
        end
        do_reset();

        // bad code sticky, then reset mid-drain
        step(1, 8'd99, 32'd0, 0, 0);
        step(1, 8'd1, 32'h7, 0, 0);
        chk("t6_bad_sticky", bad_code, 1);
        for (int i = 0; i < 2; i++) step(1, 8'd11, 32'h30 + i, 0, 0);
        step(1, 8'd17, 32'd9, 0, 0);
        step(0, 8'd0, 32'd0, 0, 0);
        chk("t6_in_drain", stall, 1);
        do_reset();

        // narrow-counter wrap through time reads
        for (int i = 0; i < 300; i++)
            step(0, 8'd0, 32'd0, 0, (i > 10) && (m_cnt_b >= 8'd254 || m_cnt_b <= 8'd1));
        enable_b = 1; #1;
        chk("t5_wrap_nonzero", rd_data_b, m_cnt_b);
        enable_b = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_syscall_unit

`default_nettype wire
